// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: op encodings, slot records,
// FSM state constants and the load-op classifier.
package mem_stage_pkg;

   localparam int ISSUE_WIDTH = 2;
   localparam int DATA_W      = 32;

   typedef enum logic [3:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      LD_B, LD_BU, LD_H, LD_HU, LD_W, LL_W,
      ST_B, ST_H, ST_W
   } alu_op_t;

   // Load-wait FSM states, kept as plain constants for older tools.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   typedef struct packed {
      logic              valid;
      alu_op_t           aluop;
      logic              reg_write_en;
      logic [4:0]        reg_write_addr;
      logic [DATA_W-1:0] reg_write_data;
      logic [31:0]       mem_addr;
   } ex_mem_t;

   typedef struct packed {
      logic              valid;
      logic              reg_write_en;
      logic [4:0]        reg_write_addr;
      logic [DATA_W-1:0] reg_write_data;
   } mem_wb_t;

   typedef struct packed {
      logic              reg_write_en;
      logic [4:0]        reg_write_addr;
      logic [DATA_W-1:0] reg_write_data;
   } pipeline_push_forward_t;

   function automatic logic is_load_op(input alu_op_t op);
      return op inside {LD_B, LD_BU, LD_H, LD_HU, LD_W, LL_W};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bus between execute/ctrl/D-cache and the memory stage.
interface mem_stage_if
   import mem_stage_pkg::*;
   ();

   logic                                        flush;
   logic                                        pause;
   ex_mem_t                [ISSUE_WIDTH-1:0]    mem_i;
   logic                                        dcache_data_ok;
   logic                   [DATA_W-1:0]         dcache_rdata;
   pipeline_push_forward_t [ISSUE_WIDTH-1:0]    mem_reg_pf;
   logic                                        pause_mem;
   mem_wb_t                [ISSUE_WIDTH-1:0]    wb_i;

   modport master (
      output flush, pause, mem_i, dcache_data_ok, dcache_rdata,
      input  mem_reg_pf, pause_mem, wb_i
   );

   modport slave (
      input  flush, pause, mem_i, dcache_data_ok, dcache_rdata,
      output mem_reg_pf, pause_mem, wb_i
   );

endinterface

// File: rtl/mem_stage_load_formatter.sv
// Extracts and extends the addressed byte/half/word of a D-cache response.
module load_formatter
   import mem_stage_pkg::*;
(
   input  alu_op_t           aluop,
   input  logic [1:0]        off,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane and extend it according to the load type.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise unlisted paths would hold their value and infer a latch.
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = rdata[{off[1], 4'b0000} +: 16];
      result   = rdata;
      case (aluop)
         LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   result = {24'h0, byte_sel};
         LD_H:    result = {{16{half_sel[15]}}, half_sel};
         LD_HU:   result = {16'h0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: waits for slot-0 load data, formats it, forwards
// results to dispatch and registers the slot pair toward writeback.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  bus
);

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] buf_q;
   logic              buf_load;
   logic              load;
   logic              pause_mem_c;
   logic [DATA_W-1:0] rdata_sel;
   logic [DATA_W-1:0] load_data;
   mem_wb_t [ISSUE_WIDTH-1:0] result;

   assign load      = bus.mem_i[0].valid && is_load_op(bus.mem_i[0].aluop);
   assign rdata_sel = (state_q == S_HOLD) ? buf_q : bus.dcache_rdata;

   load_formatter u_fmt (
      .aluop  (bus.mem_i[0].aluop),
      .off    (bus.mem_i[0].mem_addr[1:0]),
      .rdata  (rdata_sel),
      .result (load_data)
   );

   // Next state, stall request and buffer capture for the slot-0 load.
   always_comb begin
      state_d     = state_q;
      pause_mem_c = 1'b0;
      buf_load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load && !bus.dcache_data_ok) begin
               pause_mem_c = 1'b1;
               state_d     = S_WAIT;
            end else if (load && bus.pause) begin
               // A hit arriving while ctrl stalls is a one-shot pulse: keep it.
               buf_load = 1'b1;
               state_d  = S_HOLD;
            end
         end
         S_WAIT: begin
            pause_mem_c = !bus.dcache_data_ok;
            if (bus.dcache_data_ok) begin
               buf_load = bus.pause;
               state_d  = bus.pause ? S_HOLD : S_IDLE;
            end
         end
         S_HOLD: begin
            if (!bus.pause) state_d = S_IDLE;
         end
         S_DRAIN: begin
            // Any data_ok here answers the flushed load, never the current one.
            pause_mem_c = load;
            if (bus.dcache_data_ok) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.flush) begin
         buf_load = 1'b0;
         state_d  = (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !bus.dcache_data_ok)
                    ? S_DRAIN : S_IDLE;
      end
   end

   // Build this cycle's result pair and the push-forward view of it.
   always_comb begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         result[i].valid          = bus.mem_i[i].valid;
         result[i].reg_write_en   = bus.mem_i[i].reg_write_en;
         result[i].reg_write_addr = bus.mem_i[i].reg_write_addr;
         result[i].reg_write_data = bus.mem_i[i].reg_write_data;
      end
      if (load) result[0].reg_write_data = load_data;

      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         bus.mem_reg_pf[i].reg_write_en   = result[i].valid && result[i].reg_write_en;
         bus.mem_reg_pf[i].reg_write_addr = result[i].reg_write_addr;
         bus.mem_reg_pf[i].reg_write_data = result[i].reg_write_data;
      end
      if (pause_mem_c) bus.mem_reg_pf[0].reg_write_en = 1'b0;

      bus.pause_mem = pause_mem_c;
      if (rst) begin
         bus.pause_mem  = 1'b0;
         bus.mem_reg_pf = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Response buffer for data that arrives while ctrl holds the stage.
   always_ff @(posedge clk) begin
      // NOTE: pure datapath storage, qualified by the FSM, so it needs no reset.
      if (buf_load) buf_q <= bus.dcache_rdata;
   end

   // MEM->WB pipeline register: clear, bubble, load or hold.
   always_ff @(posedge clk) begin
      if (rst || bus.flush)                     bus.wb_i <= '0;
      else if (pause_mem_c || state_q == S_DRAIN) bus.wb_i <= '0;
      else if (!bus.pause)                      bus.wb_i <= result;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mem_stage_if bus ();

   mem_stage u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      alu_op_t     op;
      logic [31:0] addr;
      logic        data_ok;
      logic [31:0] rdata;
      logic [31:0] src;
      logic [31:0] exp0;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.mem_i          = '0;
      bus.dcache_data_ok = 1'b0;
      bus.dcache_rdata   = '0;
      bus.flush          = 1'b0;
      bus.pause          = 1'b0;
   endtask

   task automatic set_s0(input alu_op_t op, input logic [31:0] addr,
                         input logic [31:0] d, input logic [4:0] rd);
      bus.mem_i[0].valid          = 1'b1;
      bus.mem_i[0].aluop          = op;
      bus.mem_i[0].reg_write_en   = !(op inside {ST_B, ST_H, ST_W});
      bus.mem_i[0].reg_write_addr = rd;
      bus.mem_i[0].reg_write_data = d;
      bus.mem_i[0].mem_addr       = addr;
   endtask

   task automatic set_s1(input logic [31:0] d);
      bus.mem_i[1].valid          = 1'b1;
      bus.mem_i[1].aluop          = OP_ADD;
      bus.mem_i[1].reg_write_en   = 1'b1;
      bus.mem_i[1].reg_write_addr = 5'd5;
      bus.mem_i[1].reg_write_data = d;
      bus.mem_i[1].mem_addr       = '0;
   endtask

   initial begin
      vecs[0]  = '{OP_ADD, 32'h0,    1'b0, 32'h0,         32'h11,        32'h11};
      vecs[1]  = '{LD_B,   32'h1003, 1'b1, 32'h80FF_1234, 32'h0,         32'hFFFF_FF80};
      vecs[2]  = '{LD_BU,  32'h1003, 1'b1, 32'h80FF_1234, 32'h0,         32'h0000_0080};
      vecs[3]  = '{LD_H,   32'h1002, 1'b1, 32'h80FF_1234, 32'h0,         32'hFFFF_80FF};
      vecs[4]  = '{LD_HU,  32'h1000, 1'b1, 32'h80FF_1234, 32'h0,         32'h0000_1234};
      vecs[5]  = '{LD_B,   32'h1001, 1'b1, 32'h80FF_1234, 32'h0,         32'h0000_0012};
      vecs[6]  = '{LD_W,   32'h1000, 1'b1, 32'h80FF_1234, 32'h0,         32'h80FF_1234};
      vecs[7]  = '{LL_W,   32'h2000, 1'b1, 32'h0000_8765, 32'h0,         32'h0000_8765};
      vecs[8]  = '{LD_H,   32'h2000, 1'b1, 32'h0000_8765, 32'h0,         32'hFFFF_8765};
      vecs[9]  = '{ST_W,   32'h2004, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[10] = '{LD_B,   32'h2002, 1'b1, 32'h007F_0000, 32'h0,         32'h0000_007F};

      // Reset state
      rst = 1'b1;
      drive_idle();
      step();
      step();
      check("reset_pause_mem", {31'h0, bus.pause_mem}, 32'h0);
      check("reset_wb_i", bus.wb_i[0] | bus.wb_i[1], 32'h0);
      check("reset_pf_en", {31'h0, bus.mem_reg_pf[0].reg_write_en}, 32'h0);
      rst = 1'b0;

      // Single-cycle vectors: ALU pair, hit loads, store pass-through
      for (int i = 0; i < 11; i++) begin
         drive_idle();
         set_s0(vecs[i].op, vecs[i].addr, vecs[i].src, 5'd4);
         set_s1(32'h22 + i);
         bus.dcache_data_ok = vecs[i].data_ok;
         bus.dcache_rdata   = vecs[i].rdata;
         #1;
         check($sformatf("v%0d_pause_mem", i), {31'h0, bus.pause_mem}, 32'h0);
         check($sformatf("v%0d_pf0_data", i), bus.mem_reg_pf[0].reg_write_data, vecs[i].exp0);
         step();
         check($sformatf("v%0d_wb0_data", i), bus.wb_i[0].reg_write_data, vecs[i].exp0);
         check($sformatf("v%0d_wb0_addr", i), {27'h0, bus.wb_i[0].reg_write_addr}, 32'h4);
         check($sformatf("v%0d_wb1_data", i), bus.wb_i[1].reg_write_data, 32'h22 + i);
      end

      // Late LD_H: three wait cycles, then sign-extended upper half
      drive_idle();
      set_s0(LD_H, 32'h3002, 32'h0, 5'd6);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("late_c%0d_pause_mem", c), {31'h0, bus.pause_mem}, 32'h1);
         check($sformatf("late_c%0d_pf0_en", c), {31'h0, bus.mem_reg_pf[0].reg_write_en}, 32'h0);
         step();
         check($sformatf("late_c%0d_wb0_valid", c), {31'h0, bus.wb_i[0].valid}, 32'h0);
      end
      bus.dcache_data_ok = 1'b1;
      bus.dcache_rdata   = 32'h8001_0000;
      #1;
      check("late_ok_pause_mem", {31'h0, bus.pause_mem}, 32'h0);
      check("late_ok_pf0_en", {31'h0, bus.mem_reg_pf[0].reg_write_en}, 32'h1);
      step();
      check("late_wb0_data", bus.wb_i[0].reg_write_data, 32'hFFFF_8001);
      check("late_wb0_valid", {31'h0, bus.wb_i[0].valid}, 32'h1);

      // Response arrives under pause: buffered in HOLD, lands when pause drops
      drive_idle();
      set_s0(LD_BU, 32'h4001, 32'h0, 5'd7);
      step();
      bus.dcache_data_ok = 1'b1;
      bus.dcache_rdata   = 32'hAABB_CCDD;
      bus.pause          = 1'b1;
      step();
      check("hold_wb0_valid_a", {31'h0, bus.wb_i[0].valid}, 32'h0);
      bus.dcache_data_ok = 1'b0;
      bus.dcache_rdata   = 32'h1111_1111;
      #1;
      check("hold_pause_mem", {31'h0, bus.pause_mem}, 32'h0);
      check("hold_pf0_data", bus.mem_reg_pf[0].reg_write_data, 32'h0000_00CC);
      step();
      check("hold_wb0_valid_b", {31'h0, bus.wb_i[0].valid}, 32'h0);
      bus.pause = 1'b0;
      step();
      check("hold_wb0_data", bus.wb_i[0].reg_write_data, 32'h0000_00CC);
      check("hold_wb0_addr", {27'h0, bus.wb_i[0].reg_write_addr}, 32'h7);

      // Flush clears a registered result
      drive_idle();
      set_s0(OP_ADD, 32'h0, 32'h99, 5'd4);
      set_s1(32'h77);
      step();
      check("pre_flush_wb1", bus.wb_i[1].reg_write_data, 32'h77);
      bus.flush = 1'b1;
      step();
      check("flush_wb0_valid", {31'h0, bus.wb_i[0].valid}, 32'h0);
      check("flush_wb1_data", bus.wb_i[1].reg_write_data, 32'h0);

      // Flush during WAIT: stale response swallowed, next LD_W gets its own
      drive_idle();
      set_s0(LD_W, 32'h5000, 32'h0, 5'd8);
      step();
      drive_idle();
      bus.flush = 1'b1;
      step();
      check("drain_wb0_valid", {31'h0, bus.wb_i[0].valid}, 32'h0);
      bus.flush = 1'b0;
      step();
      set_s0(LD_W, 32'h6000, 32'h0, 5'd9);
      bus.dcache_data_ok = 1'b1;
      bus.dcache_rdata   = 32'h5555_AAAA;
      #1;
      check("drain_stale_pause_mem", {31'h0, bus.pause_mem}, 32'h1);
      step();
      check("drain_stale_wb0_valid", {31'h0, bus.wb_i[0].valid}, 32'h0);
      bus.dcache_rdata = 32'h1234_5678;
      #1;
      check("drain_new_pause_mem", {31'h0, bus.pause_mem}, 32'h0);
      step();
      check("drain_new_wb0_data", bus.wb_i[0].reg_write_data, 32'h1234_5678);
      check("drain_new_wb0_addr", {27'h0, bus.wb_i[0].reg_write_addr}, 32'h9);

      // Reset mid-WAIT returns to IDLE
      drive_idle();
      set_s0(LD_W, 32'h7000, 32'h0, 5'd10);
      step();
      rst = 1'b1;
      #1;
      check("rst_wait_pause_mem", {31'h0, bus.pause_mem}, 32'h0);
      check("rst_wait_pf0_en", {31'h0, bus.mem_reg_pf[0].reg_write_en}, 32'h0);
      step();
      check("rst_wait_wb0_valid", {31'h0, bus.wb_i[0].valid}, 32'h0);
      rst = 1'b0;
      drive_idle();
      set_s0(OP_ADD, 32'h0, 32'h33, 5'd4);
      #1;
      check("post_rst_pause_mem", {31'h0, bus.pause_mem}, 32'h0);
      step();
      check("post_rst_wb0_data", bus.wb_i[0].reg_write_data, 32'h33);

      drive_idle();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
